// File: rtl/vga_text_console.sv
// vga_text_console: byte stream to vga text write port; keeps a cursor, handles CR/LF/BS, FF clears the screen.
// Latency: one cycle from accept to write_strobe. Backpressure: in_ready low while the clear sequence runs.
// Define VGA_CONSOLE_CLEAR_ON_RESET_EN to start in the clear sequence after every reset.
module vga_text_console #(
    parameter int          COLS  = 80,
    parameter int          ROWS  = 25,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  in_char,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  write_char,
    output logic [10:0] write_pos,
    output logic        write_strobe,
    output logic [10:0] cursor_pos,
    output logic        busy
);

    localparam int               CW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [11:0]      NPOS     = 12'(COLS * ROWS);
    localparam logic [11:0]      POS_LAST = 12'(COLS * ROWS - 1);
    localparam logic [11:0]      NCOL     = 12'(COLS);
    localparam logic [CW-1:0]    COL_LAST = CW'(COLS - 1);
    localparam logic [CW-1:0]    COL_ONE  = CW'(1);

    typedef enum logic {IDLE, CLEAR} state_t;

`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
    localparam state_t RST_STATE = CLEAR;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [11:0]   pos_q, pos_d;
    logic [11:0]   clr_q, clr_d;
    logic [7:0]    char_q, char_d;
    logic [10:0]   wpos_q, wpos_d;
    logic          strobe_q, strobe_d;

    logic [11:0]   line_start, lf_pos, pos_dec;

    // 12-bit arithmetic so row start + COLS can reach COLS*ROWS without overflow.
    assign line_start = pos_q - 12'(col_q);
    assign lf_pos     = line_start + NCOL;
    assign pos_dec    = pos_q - 12'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= RST_STATE;
            col_q    <= '0;
            pos_q    <= '0;
            clr_q    <= '0;
            char_q   <= '0;
            wpos_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            pos_q    <= pos_d;
            clr_q    <= clr_d;
            char_q   <= char_d;
            wpos_q   <= wpos_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        pos_d    = pos_q;
        clr_d    = clr_q;
        char_d   = char_q;
        wpos_d   = wpos_q;
        strobe_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    case (in_char)
                        8'h0A: begin
                            col_d = '0;
                            pos_d = (lf_pos == NPOS) ? 12'd0 : lf_pos;
                        end
                        8'h0D: begin
                            col_d = '0;
                            pos_d = line_start;
                        end
                        8'h08: begin
                            if (col_q != '0) begin
                                col_d    = col_q - COL_ONE;
                                pos_d    = pos_dec;
                                char_d   = BLANK;
                                wpos_d   = pos_dec[10:0];
                                strobe_d = 1'b1;
                            end
                        end
                        8'h0C: begin
                            state_d = CLEAR;
                            clr_d   = '0;
                        end
                        default: begin
                            char_d   = in_char;
                            wpos_d   = pos_q[10:0];
                            strobe_d = 1'b1;
                            if (pos_q == POS_LAST) begin
                                pos_d = '0;
                                col_d = '0;
                            end else begin
                                pos_d = pos_q + 12'd1;
                                col_d = (col_q == COL_LAST) ? '0 : col_q + COL_ONE;
                            end
                        end
                    endcase
                end
            end
            CLEAR: begin
                // One tail cycle after the last blank so in_ready rises the cycle after the final strobe.
                if (clr_q != NPOS) begin
                    char_d   = BLANK;
                    wpos_d   = clr_q[10:0];
                    strobe_d = 1'b1;
                    clr_d    = clr_q + 12'd1;
                end else begin
                    state_d = IDLE;
                    pos_d   = '0;
                    col_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q == CLEAR);
    assign write_char   = char_q;
    assign write_pos    = wpos_q;
    assign write_strobe = strobe_q;
    assign cursor_pos   = pos_q[10:0];

endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: directed sequences plus random bytes against a cursor/screen-write reference model.
module tb_vga_text_console;

    localparam int COLS = 80;
    localparam int ROWS = 25;
    localparam int NP   = COLS * ROWS;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [7:0]  in_char = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  write_char;
    logic [10:0] write_pos;
    logic        write_strobe;
    logic [10:0] cursor_pos;
    logic        busy;

    vga_text_console dut (
        .CLK(CLK), .RST_N(RST_N), .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready),
        .write_char(write_char), .write_pos(write_pos), .write_strobe(write_strobe),
        .cursor_pos(cursor_pos), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int ch;
        int pos;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   mpos = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int ch, input int p, input int cy);
        exp_t e;
        e.ch = ch; e.pos = p; e.cyc = cy;
        sb.push_back(e);
    endtask

    // Reference: cursor as a plain linear index, expected writes with the cycle they must appear in.
    task automatic model(input logic [7:0] b, input int c);
        int col;
        col = mpos % COLS;
        case (b)
            8'h0A: begin mpos = mpos - col + COLS; if (mpos == NP) mpos = 0; end
            8'h0D: mpos = mpos - col;
            8'h08: if (col > 0) begin mpos = mpos - 1; push(32, mpos, c + 1); end
            8'h0C: begin for (int i = 0; i < NP; i++) push(32, i, c + 2 + i); mpos = 0; end
            default: begin push(int'(b), mpos, c + 1); mpos = (mpos + 1) % NP; end
        endcase
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic send(input logic [7:0] b, input bit chk_cur, output int acc);
        int w;
        w = 0;
        acc = -1;
        in_char = b;
        in_valid = 1'b1;
        while (!in_ready && w < 5000) begin
            @(negedge CLK);
            w++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            acc = cyc;
            model(b, cyc);
            @(posedge CLK);
            @(negedge CLK);
            in_valid = 1'b0;
            if (chk_cur) chk("cursor", int'(cursor_pos), mpos);
        end
    endtask

    task automatic put(input logic [7:0] b);
        int a;
        send(b, b != 8'h0C, a);
    endtask

    task automatic do_reset();
        int c;
        #2 RST_N = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_write_strobe", int'(write_strobe), 0);
        chk("rst_write_char", int'(write_char), 0);
        chk("rst_write_pos", int'(write_pos), 0);
        chk("rst_cursor", int'(cursor_pos), 0);
`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
        chk("rst_busy", int'(busy), 1);
`else
        chk("rst_busy", int'(busy), 0);
`endif
        sb.delete();
        mpos = 0;
        @(negedge CLK);
        @(negedge CLK);
        #1 RST_N = 1'b1;
        c = cyc;
`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
        for (int i = 0; i < NP; i++) push(32, i, c + 1 + i);
        @(negedge CLK);
        chk("rst_clear_in_ready", int'(in_ready), 0);
        for (int w = 0; w < 5000 && !in_ready; w++) @(negedge CLK);
        chk("rst_clear_ready_cycle", cyc, c + NP + 1);
`else
        @(negedge CLK);
        chk("rst_in_ready", int'(in_ready), 1);
`endif
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST_N && write_strobe) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe_pos", int'(write_pos), -1);
            end else begin
                e = sb.pop_front();
                chk("strobe_char", int'(write_char), e.ch);
                chk("strobe_pos", int'(write_pos), e.pos);
                chk("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, queue=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a, c0, r;
        do_reset();

        // "AB" back to back, then fill to end of row with X at 78 and Y at 79
        put(8'h41);
        put(8'h42);
        for (int i = 0; i < 76; i++) put(8'h61 + 8'(i % 26));
        put(8'h58);
        put(8'h59);
        chk("row1_start", int'(cursor_pos), 80);

        // LF/CR from 83, LF wrap from row 24
        for (int i = 0; i < 3; i++) put(8'h30 + 8'(i));
        put(8'h0A);
        chk("lf_83", int'(cursor_pos), 160);
        put(8'h0D);
        chk("cr_160", int'(cursor_pos), 160);
        for (int i = 0; i < 22; i++) put(8'h0A);
        for (int i = 0; i < 5; i++) put(8'h2E);
        chk("at_1925", int'(cursor_pos), 1925);
        put(8'h0A);
        chk("lf_wrap", int'(cursor_pos), 0);

        // BS mid-row and at column 0
        for (int i = 0; i < 5; i++) put(8'h7E);
        put(8'h08);
        chk("bs_5", int'(cursor_pos), 4);
        put(8'h0A);
        put(8'h08);
        chk("bs_col0", int'(cursor_pos), 80);

        // FF with 'Z' held during the clear
        send(8'h0C, 1'b0, c0);
        chk("ff_busy", int'(busy), 1);
        chk("ff_in_ready", int'(in_ready), 0);
        send(8'h5A, 1'b1, a);
        chk("ff_ready_cycle", a, c0 + NP + 2);
        chk("z_cursor", int'(cursor_pos), 1);

        // Random bytes with occasional idle gaps
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       put(8'h0A);
            else if (r < 14) put(8'h0D);
            else if (r < 26) put(8'h08);
            else if (r < 27) put(8'h0C);
            else             put(8'($urandom_range(32, 126)));
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
        end
        chk("random_cursor", int'(cursor_pos), mpos);

        // Reset during a clear after 700 blanks
        put(8'h41);
        send(8'h0C, 1'b0, c0);
        while (cyc < c0 + 701) @(negedge CLK);
        do_reset();
        put(8'h51);
        chk("after_reset_cursor", int'(cursor_pos), 1);

        repeat (5) @(negedge CLK);
        chk("queue_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
